// File: rtl/partition_binner.sv
// Bins screen-space triangle bounding boxes into a PARTITIONS x PARTITIONS grid,
// writing one (model, offset) entry per covered partition and keeping per-partition counts.
module partition_binner #(
    parameter int unsigned RES_X       = 64,
    parameter int unsigned RES_Y       = 64,
    parameter int unsigned PARTITIONS  = 4,
    parameter int unsigned MAX_ENTRIES = 32,
    parameter int unsigned MODEL_W     = 8,
    parameter int unsigned TRI_W       = 16,
    localparam int unsigned XW = $clog2(RES_X),
    localparam int unsigned YW = $clog2(RES_Y),
    localparam int unsigned PW = $clog2(PARTITIONS * PARTITIONS),
    localparam int unsigned SW = $clog2(MAX_ENTRIES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [MODEL_W-1:0] tri_model,
    input  logic [TRI_W-1:0]   tri_offset,
    input  logic [XW-1:0]      tri_xmin,
    input  logic [XW-1:0]      tri_xmax,
    input  logic [YW-1:0]      tri_ymin,
    input  logic [YW-1:0]      tri_ymax,
    output logic               wr_en,
    output logic [PW-1:0]      wr_part,
    output logic [SW-1:0]      wr_slot,
    output logic [MODEL_W-1:0] wr_model,
    output logic [TRI_W-1:0]   wr_offset,
    input  logic [PW-1:0]      cnt_rd_part,
    output logic [SW-1:0]      cnt_rd_data,
    output logic               overflow,
    output logic               busy
);

    localparam int unsigned PB    = $clog2(PARTITIONS);
    localparam int unsigned NPART = PARTITIONS * PARTITIONS;
    localparam int unsigned XSH   = XW - PB;
    localparam int unsigned YSH   = YW - PB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WALK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            pending_q, pending_d;
    logic [PB-1:0]   px0_q, px1_q, py1_q;
    logic [PB-1:0]   cx_q, cy_q;
    logic [SW-1:0]   cnt_q [NPART];

    logic [PB-1:0]   in_px0, in_px1, in_py0, in_py1;
    logic            degenerate;
    logic            issue, load, clear;
    logic [PB-1:0]   issue_x, issue_y;
    logic [PW-1:0]   issue_part;
    logic [SW-1:0]   issue_cnt;
    logic            issue_room;
    logic [SW-1:0]   rd_next;

    assign in_px0     = PB'(tri_xmin >> XSH);
    assign in_px1     = PB'(tri_xmax >> XSH);
    assign in_py0     = PB'(tri_ymin >> YSH);
    assign in_py1     = PB'(tri_ymax >> YSH);
    assign degenerate = (tri_xmin > tri_xmax) || (tri_ymin > tri_ymax);

    assign issue_part = PW'({issue_y, issue_x});
    assign issue_cnt  = cnt_q[issue_part];
    assign issue_room = issue_cnt < SW'(MAX_ENTRIES);

    // Next state; 'issue' selects the partition whose write is registered on this edge.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tri_ready = 1'b0;
        issue     = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        issue_x   = cx_q;
        issue_y   = cy_q;
        case (state_q)
            IDLE: begin
                tri_ready = !pending_q && !frame_start;
                if (pending_q || frame_start) begin
                    state_d = CLEAR;
                end else if (tri_valid) begin
                    load = 1'b1;
                    if (!degenerate) begin
                        issue   = 1'b1;
                        issue_x = in_px0;
                        issue_y = in_py0;
                        state_d = WALK;
                    end
                end
            end
            CLEAR: begin
                clear     = 1'b1;
                pending_d = frame_start;
                state_d   = IDLE;
            end
            WALK: begin
                if (frame_start) begin
                    pending_d = 1'b1;
                end
                if (cx_q == px1_q && cy_q == py1_q) begin
                    state_d = IDLE;
                end else begin
                    issue = 1'b1;
                    if (cx_q == px1_q) begin
                        issue_x = px0_q;
                        issue_y = PB'(cy_q + PB'(1));
                    end else begin
                        issue_x = PB'(cx_q + PB'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port sees the counter value as it will be after this edge.
    always_comb begin
        rd_next = cnt_q[cnt_rd_part];
        if (clear) begin
            rd_next = '0;
        end else if (issue && issue_room && issue_part == cnt_rd_part) begin
            rd_next = SW'(cnt_q[cnt_rd_part] + SW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            busy        <= 1'b0;
            px0_q       <= '0;
            px1_q       <= '0;
            py1_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            wr_en       <= 1'b0;
            wr_part     <= '0;
            wr_slot     <= '0;
            wr_model    <= '0;
            wr_offset   <= '0;
            overflow    <= 1'b0;
            cnt_rd_data <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            busy        <= (state_d != IDLE);
            cnt_rd_data <= rd_next;
            wr_en       <= issue && issue_room;
            if (load) begin
                px0_q     <= in_px0;
                px1_q     <= in_px1;
                py1_q     <= in_py1;
                wr_model  <= tri_model;
                wr_offset <= tri_offset;
            end
            if (issue) begin
                cx_q    <= issue_x;
                cy_q    <= issue_y;
                wr_part <= issue_part;
                wr_slot <= issue_cnt;
            end
            if (clear) begin
                overflow <= 1'b0;
            end else if (issue && !issue_room) begin
                overflow <= 1'b1;
            end
        end
    end

    // Per-partition entry counters, saturating at MAX_ENTRIES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NPART); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(NPART); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (issue && issue_room) begin
            cnt_q[issue_part] <= SW'(issue_cnt + SW'(1));
        end
    end

endmodule

// File: tb/tb_partition_binner.sv
// Bench for partition_binner: directed scenarios plus randomized boxes checked
// against a per-partition counter model built from pixel-to-partition arithmetic.
module tb_partition_binner;

    typedef struct packed {
        logic [3:0]  part;
        logic [5:0]  slot;
        logic [7:0]  model;
        logic [15:0] off;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [7:0]  tri_model = '0;
    logic [15:0] tri_offset = '0;
    logic [5:0]  tri_xmin = '0, tri_xmax = '0, tri_ymin = '0, tri_ymax = '0;
    logic        wr_en;
    logic [3:0]  wr_part;
    logic [5:0]  wr_slot;
    logic [7:0]  wr_model;
    logic [15:0] wr_offset;
    logic [3:0]  cnt_rd_part = '0;
    logic [5:0]  cnt_rd_data;
    logic        overflow;
    logic        busy;

    int   checks = 0;
    int   passed = 0;
    ent_t obs[$];
    ent_t exp_q[$];
    int   mcnt[16];
    bit   movf;
    int   exp_cycles;

    partition_binner #(
        .RES_X(64), .RES_Y(64), .PARTITIONS(4), .MAX_ENTRIES(32), .MODEL_W(8), .TRI_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_model(tri_model), .tri_offset(tri_offset),
        .tri_xmin(tri_xmin), .tri_xmax(tri_xmax), .tri_ymin(tri_ymin), .tri_ymax(tri_ymax),
        .wr_en(wr_en), .wr_part(wr_part), .wr_slot(wr_slot),
        .wr_model(wr_model), .wr_offset(wr_offset),
        .cnt_rd_part(cnt_rd_part), .cnt_rd_data(cnt_rd_data),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: each partition is a 16x16 pixel tile; visit tiles row by row.
    function automatic void model_box(int m, int off, int x0, int x1, int y0, int y1);
        exp_q.delete();
        exp_cycles = 0;
        if (x0 > x1 || y0 > y1) return;
        for (int ty = y0 / 16; ty <= y1 / 16; ty++) begin
            for (int tx = x0 / 16; tx <= x1 / 16; tx++) begin
                int p = ty * 4 + tx;
                exp_cycles++;
                if (mcnt[p] < 32) begin
                    exp_q.push_back('{part: 4'(p), slot: 6'(mcnt[p]), model: 8'(m), off: 16'(off)});
                    mcnt[p]++;
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        movf = 1'b0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!tri_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tri_ready) begin
            checks++;
            $display("FAIL ready_timeout: tri_ready=%0b after %0d cycles, required 1", tri_ready, n);
        end
    endtask

    // Offers one box, then records writes and not-ready cycles until tri_ready returns.
    task automatic do_box(input int m, input int off, input int x0, input int x1,
                          input int y0, input int y1, input int fs_at, output int low);
        obs.delete();
        wait_ready();
        tri_model  = 8'(m);
        tri_offset = 16'(off);
        tri_xmin   = 6'(x0);
        tri_xmax   = 6'(x1);
        tri_ymin   = 6'(y0);
        tri_ymax   = 6'(y1);
        tri_valid  = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
        low = 0;
        @(negedge clk);
        while (!tri_ready && low < 200) begin
            if (wr_en) obs.push_back('{part: wr_part, slot: wr_slot, model: wr_model, off: wr_offset});
            if (low == fs_at) begin
                frame_start = 1'b1;
                @(posedge clk);
                #1 frame_start = 1'b0;
            end
            low++;
            @(negedge clk);
        end
        if (!tri_ready) begin
            checks++;
            $display("FAIL walk_timeout: tri_ready=%0b after %0d cycles, required 1", tri_ready, low);
        end
    endtask

    task automatic read_cnt(input int p, output int v);
        @(negedge clk);
        cnt_rd_part = 4'(p);
        @(negedge clk);
        v = int'(cnt_rd_data);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_ready();
    endtask

    task automatic test_reset();
        #22 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tri_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", tri_ready); else passed++;
        checks++; if ({wr_en, busy, overflow} !== 3'b000) $display("FAIL reset_flags: wr_en/busy/ovf got %b, required 000", {wr_en, busy, overflow}); else passed++;
        checks++; if ({wr_part, wr_slot, wr_model, wr_offset} !== '0) $display("FAIL reset_wr: got %h, required 0", {wr_part, wr_slot, wr_model, wr_offset}); else passed++;
        checks++; if (cnt_rd_data !== 6'd0) $display("FAIL reset_cnt: got %0d, required 0", cnt_rd_data); else passed++;
    endtask

    task automatic test_three_parts();
        int low, v;
        int want[4] = '{1, 1, 1, 0};
        do_box(1, 100, 10, 40, 0, 15, -1, low);
        checks++; if (low !== 3) $display("FAIL three_busy_cycles: got %0d, required 3", low); else passed++;
        checks++; if (obs.size() !== 3) $display("FAIL three_writes: got %0d, required 3", obs.size()); else passed++;
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== ent_t'{part: 4'(i), slot: 6'd0, model: 8'd1, off: 16'd100})
                $display("FAIL three_entry%0d: got %h, required part %0d slot 0 model 1 off 100", i, obs[i], i);
            else passed++;
        end
        for (int p = 0; p < 4; p++) begin
            read_cnt(p, v);
            checks++; if (v !== want[p]) $display("FAIL three_cnt%0d: got %0d, required %0d", p, v, want[p]); else passed++;
        end
    endtask

    task automatic test_full_screen();
        int low;
        do_box(2, 200, 0, 63, 0, 63, -1, low);
        checks++; if (low !== 16) $display("FAIL full_busy_cycles: got %0d, required 16", low); else passed++;
        checks++; if (obs.size() !== 16) $display("FAIL full_writes: got %0d, required 16", obs.size()); else passed++;
        foreach (obs[i]) begin
            checks++;
            if (obs[i].part !== 4'(i) || obs[i].slot !== ((i < 3) ? 6'd1 : 6'd0))
                $display("FAIL full_entry%0d: got part %0d slot %0d, required part %0d slot %0d",
                         i, obs[i].part, obs[i].slot, i, (i < 3) ? 1 : 0);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        int low, v;
        pulse_frame();
        for (int k = 0; k < 33; k++) begin
            do_box(3, k, 0, 0, 0, 0, -1, low);
            checks++;
            if (k < 32) begin
                if (obs.size() !== 1 || obs[0].slot !== 6'(k) || obs[0].part !== 4'd0 || low !== 1)
                    $display("FAIL ovf_fill%0d: got %0d writes slot %0d low %0d, required 1 write slot %0d low 1",
                             k, obs.size(), (obs.size() > 0) ? int'(obs[0].slot) : -1, low, k);
                else passed++;
            end else begin
                if (obs.size() !== 0) $display("FAIL ovf_drop: got %0d writes, required 0", obs.size());
                else passed++;
            end
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b, required 1", overflow); else passed++;
        read_cnt(0, v);
        checks++; if (v !== 32) $display("FAIL ovf_cnt0: got %0d, required 32", v); else passed++;
    endtask

    task automatic test_degenerate();
        int low, v;
        do_box(4, 9, 20, 5, 0, 63, -1, low);
        checks++; if (low !== 0 || wr_en !== 1'b0) $display("FAIL degen_ready: got low %0d wr_en %0b, required 0 0", low, wr_en); else passed++;
        checks++; if (obs.size() !== 0) $display("FAIL degen_writes: got %0d, required 0", obs.size()); else passed++;
        read_cnt(0, v);
        checks++; if (v !== 32 || overflow !== 1'b1) $display("FAIL degen_state: got cnt %0d ovf %0b, required 32 1", v, overflow); else passed++;
    endtask

    task automatic test_frame_mid_walk();
        int low, v;
        pulse_frame();
        do_box(5, 7, 0, 63, 0, 63, 5, low);
        checks++; if (obs.size() !== 16) $display("FAIL fs_walk_writes: got %0d, required 16", obs.size()); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL fs_ovf: got %0b, required 0", overflow); else passed++;
        for (int p = 0; p < 16; p++) begin
            read_cnt(p, v);
            checks++; if (v !== 0) $display("FAIL fs_cnt%0d: got %0d, required 0", p, v); else passed++;
        end
        do_box(6, 8, 0, 0, 0, 0, -1, low);
        checks++; if (obs.size() !== 1 || obs[0].slot !== 6'd0) $display("FAIL fs_next_slot: got %0d writes, required 1 write at slot 0", obs.size()); else passed++;
    endtask

    task automatic test_random();
        int low, v, x0, x1, y0, y1;
        pulse_frame();
        model_clear();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_frame();
                model_clear();
            end
            x0 = $urandom_range(0, 63);
            y0 = $urandom_range(0, 63);
            if ($urandom_range(0, 6) == 0) begin
                x1 = $urandom_range(0, 63);
                y1 = $urandom_range(0, 63);
            end else begin
                x1 = $urandom_range(x0, 63);
                y1 = $urandom_range(y0, 63);
            end
            model_box(t + 10, int'($urandom_range(0, 65535)), x0, x1, y0, y1);
            do_box(t + 10, int'(exp_q.size() > 0 ? exp_q[0].off : 16'd0), x0, x1, y0, y1, -1, low);
            checks++; if (low !== exp_cycles) $display("FAIL rnd%0d_cycles: got %0d, required %0d", t, low, exp_cycles); else passed++;
            checks++; if (obs.size() !== exp_q.size()) $display("FAIL rnd%0d_nwrites: got %0d, required %0d", t, obs.size(), exp_q.size()); else passed++;
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                checks++; if (obs[i] !== exp_q[i]) $display("FAIL rnd%0d_entry%0d: got %h, required %h", t, i, obs[i], exp_q[i]); else passed++;
            end
            checks++; if (overflow !== movf) $display("FAIL rnd%0d_ovf: got %0b, required %0b", t, overflow, movf); else passed++;
        end
        for (int p = 0; p < 16; p++) begin
            read_cnt(p, v);
            checks++; if (v !== mcnt[p]) $display("FAIL rnd_cnt%0d: got %0d, required %0d", p, v, mcnt[p]); else passed++;
        end
    endtask

    task automatic test_reset_mid_walk();
        int v;
        wait_ready();
        tri_xmin = 6'd0; tri_xmax = 6'd63; tri_ymin = 6'd0; tri_ymax = 6'd63;
        tri_valid = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wr_en !== 1'b1 || busy !== 1'b1) $display("FAIL rstwalk_active: got wr_en %0b busy %0b, required 1 1", wr_en, busy); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL rstwalk_async: got wr_en %0b busy %0b, required 0 0", wr_en, busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tri_ready !== 1'b1 || overflow !== 1'b0) $display("FAIL rstwalk_ready: got ready %0b ovf %0b, required 1 0", tri_ready, overflow); else passed++;
        for (int p = 0; p < 16; p++) begin
            read_cnt(p, v);
            checks++; if (v !== 0) $display("FAIL rstwalk_cnt%0d: got %0d, required 0", p, v); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_three_parts();
        test_full_screen();
        test_overflow();
        test_degenerate();
        test_frame_mid_walk();
        test_random();
        test_reset_mid_walk();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/partition_binner.md
# partition_binner

Upstream stage of the per-pixel rasterizer. Consumes one screen-space triangle bounding box per handshake and appends a (model id, triangle offset) entry to the list of every partition the box covers. The rasterizer later walks these lists and reads the per-partition entry counters through this block. Entry storage is an external RAM written through a simple write port. The per-partition counters and the overflow flag are held here.

## Interface
- RES_X, 64: horizontal resolution in pixels; power of two.
- RES_Y, 64: vertical resolution in pixels; power of two.
- PARTITIONS, 4: partitions per axis; power of two; must divide RES_X and RES_Y. Grid holds PARTITIONS*PARTITIONS cells.
- MAX_ENTRIES, 32: entry capacity per partition.
- MODEL_W, 8: model index width.
- TRI_W, 16: triangle offset width, pointing into the model's screen-coordinate cache.

Ports (XW = clog2(RES_X), YW = clog2(RES_Y), PW = clog2(PARTITIONS*PARTITIONS), SW = clog2(MAX_ENTRIES+1)):
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse; clears all counters and overflow.
- tri_valid  in  1  triangle offered.
- tri_ready  out  1  block accepts a triangle this cycle.
- tri_model  in  MODEL_W  model index.
- tri_offset  in  TRI_W  triangle offset.
- tri_xmin, tri_xmax  in  XW  inclusive pixel bounding box, x.
- tri_ymin, tri_ymax  in  YW  inclusive pixel bounding box, y.
- wr_en  out  1  entry write strobe.
- wr_part  out  PW  partition index = pary*PARTITIONS + parx.
- wr_slot  out  SW  slot within partition; equals the counter value before increment.
- wr_model, wr_offset  out  MODEL_W, TRI_W  entry payload.
- cnt_rd_part  in  PW  counter read address.
- cnt_rd_data  out  SW  counter of cnt_rd_part; registered.
- overflow  out  1  sticky; at least one entry was dropped this frame.
- busy  out  1  high in CLEAR or WALK.

## Operation
- Partition mapping: parx = x >> (XW - clog2(PARTITIONS)), pary = y >> (YW - clog2(PARTITIONS)).
- State IDLE: tri_ready = 1 unless a frame_start is pending or asserted.
  - frame_start (live or pending) has priority → CLEAR.
  - Else, on tri_valid && tri_ready, latch payload and partition bounds (px0..px1, py0..py1).
  - Degenerate box (xmin > xmax or ymin > ymax): accepted, no writes, stay IDLE.
  - Otherwise → WALK with cursor (px0, py0).
- State CLEAR: one cycle. All counters ← 0, overflow ← 0, pending flag ← 0 → IDLE.
- State WALK: one partition per cycle, row-major: parx increments first, then wraps to px0 and pary increments.
  - If counter[part] < MAX_ENTRIES: wr_en = 1, wr_slot = counter, counter += 1.
  - Else: wr_en = 0, overflow ← 1.
  - After visiting (px1, py1) → IDLE.
- frame_start seen outside IDLE sets a pending flag. The current walk completes unmodified, then the block enters CLEAR.
- Counters saturate at MAX_ENTRIES and never wrap.

## Timing
- Reset values: state IDLE, all counters 0, overflow 0, pending 0, wr_en 0, wr_part/wr_slot/wr_model/wr_offset 0, cnt_rd_data 0, busy 0. tri_ready = 1 in the first cycle after reset release.
- wr_* outputs are registered; wr_en drives the external RAM write directly.
- Accept at edge N: first write presented in cycle N+1. For a box covering C partitions, writes occupy cycles N+1..N+C, and tri_ready returns in cycle N+C+1.
- Sustained throughput is C+1 cycles per triangle. A degenerate box takes 1 cycle.
- cnt_rd_data reflects the counter value one cycle after cnt_rd_part is sampled, including updates made on that same edge.
- A counter read issued during CLEAR returns 0 on the following cycle.
- Reset asserted mid-WALK aborts the walk immediately; partial writes are not undone, and counters return to 0.

## Test plan
- Reset, then box x 10..40, y 0..15 (RES 64, P 4): 3 writes, parts 0,1,2, slot 0 each. tri_ready low for 3 cycles. cnt_rd_data = 1 for parts 0–2, 0 for part 3.
- Full-screen box 0..63 × 0..63: 16 writes, parts in order 0..15, then tri_ready high in cycle 17.
- 33 triangles each with box 0..0 × 0..0: slots 0..31 written. The 33rd produces no wr_en, overflow = 1, counter[0] = 32.
- Degenerate box xmin 20 > xmax 5: tri_ready stays high, no wr_en, counters unchanged.
- frame_start mid-walk of a 16-partition box: all 16 writes complete, then one CLEAR cycle. Counters read 0 and overflow = 0; next triangle writes slot 0.
- rst_n pulsed low during WALK: wr_en drops asynchronously, all counters read 0, tri_ready = 1 after release.
